// File: rtl/violation_log_buffer.sv
// Violation log buffer: filters blank plates and camera re-fire duplicates,
// then queues the surviving records in a FIFO for the log writer.
//
// Stream handshakes (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready depends only on registered
// state. out_valid and out_* are registered and stay stable until accepted.
module violation_log_buffer #(
  parameter int DEPTH      = 16,
  parameter int PLATE_W    = 15,
  parameter int TIME_W     = 19,
  parameter int DUP_WINDOW = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PLATE_W-1:0]         in_plate,
  input  logic [2:0]                 in_board,
  input  logic [TIME_W-1:0]          in_time,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PLATE_W-1:0]         out_plate,
  output logic [2:0]                 out_board,
  output logic [TIME_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                drop_count,
  output logic [7:0]                 dup_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = PLATE_W + 3 + TIME_W;

  logic [RW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_next;
  logic [LW-1:0]      level_q;
  logic [LW-1:0]      level_next;
  logic [LW-1:0]      after_pop;
  logic [RW-1:0]      head_q;
  logic               out_valid_q;

  logic               last_valid;
  logic [PLATE_W-1:0] last_plate;
  logic [2:0]         last_board;
  logic [TIME_W-1:0]  last_time;

  logic [TIME_W-1:0]  time_diff;
  logic               is_blank;
  logic               is_dup;
  logic               wr_en;
  logic               drop_ev;
  logic               dup_ev;
  logic               pop;
  logic [RW-1:0]      in_rec;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign in_ready  = ~full;
  assign level     = level_q;
  assign out_valid = out_valid_q;
  assign out_plate = head_q[RW-1 -: PLATE_W];
  assign out_board = head_q[TIME_W +: 3];
  assign out_time  = head_q[TIME_W-1:0];
  assign in_rec    = {in_plate, in_board, in_time};

  // Filter classification and FIFO pointer/level arithmetic for this cycle.
  always_comb begin
    time_diff  = in_time - last_time;  // modulo 2^TIME_W handles clock wrap
    is_blank   = (in_plate == '0);
    is_dup     = last_valid && (in_plate == last_plate) &&
                 (in_board == last_board) && (time_diff < TIME_W'(DUP_WINDOW));
    dup_ev     = in_valid && !is_blank && is_dup;
    drop_ev    = in_valid && !is_blank && !is_dup && full;
    wr_en      = in_valid && !is_blank && !is_dup && !full;
    pop        = out_valid_q && out_ready;
    rd_next    = rd_ptr + AW'(pop);
    after_pop  = level_q - LW'(pop);
    level_next = after_pop + LW'(wr_en);
  end

  // Record storage; no reset needed since level gates what is visible.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_ptr] <= in_rec;
    end
  end

  // Pointers, level, last-record tracking, counters and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      last_valid  <= 1'b0;
      last_plate  <= '0;
      last_board  <= '0;
      last_time   <= '0;
      drop_count  <= '0;
      dup_count   <= '0;
    end else begin
      rd_ptr      <= rd_next;
      level_q     <= level_next;
      out_valid_q <= (level_next != '0);
      if (wr_en) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_valid <= 1'b1;
        last_plate <= in_plate;
        last_board <= in_board;
        last_time  <= in_time;
      end
      // The new record becomes head directly when nothing else remains queued.
      if (wr_en && (after_pop == '0)) begin
        head_q <= in_rec;
      end else if (level_next != '0) begin
        head_q <= mem[rd_next];
      end
      if (drop_ev && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (dup_ev && (dup_count != 8'hFF)) begin
        dup_count <= dup_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_violation_log_buffer.sv
// Directed bench for violation_log_buffer with an expected-record queue.
module tb_violation_log_buffer;
  localparam int RW = 15 + 3 + 19;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_plate = '0;
  logic [2:0]  in_board = '0;
  logic [18:0] in_time = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] out_plate;
  logic [2:0]  out_board;
  logic [18:0] out_time;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic [15:0] drop_count;
  logic [7:0]  dup_count;

  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  violation_log_buffer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_plate(in_plate), .in_board(in_board), .in_time(in_time),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_plate(out_plate), .out_board(out_board), .out_time(out_time),
    .level(level), .full(full), .empty(empty),
    .drop_count(drop_count), .dup_count(dup_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: at the falling edge, compare the head if it is being taken.
  task automatic cycle();
    logic [RW-1:0] exp_rec;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed=%0h expected=none",
               {out_plate, out_board, out_time});
      end else begin
        exp_rec = exp_q.pop_front();
        chk("out_record", 64'({out_plate, out_board, out_time}), 64'(exp_rec));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] p, input logic [2:0] b,
                      input logic [18:0] t, input bit acc);
    in_valid = 1'b1;
    in_plate = p;
    in_board = b;
    in_time  = t;
    if (acc) exp_q.push_back({p, b, t});
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && budget < 100) begin
      cycle();
      budget++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", 64'(budget >= 100), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_fields", 64'({out_plate, out_board, out_time}), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_dup", 64'(dup_count), 64'd0);

    // Single record, one-cycle latency, then pop
    send(15'h0C63, 3'd2, 19'd100, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_plate", 64'(out_plate), 64'h0C63);
    chk("single_board", 64'(out_board), 64'd2);
    chk("single_time", 64'(out_time), 64'd100);
    chk("single_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_out_valid", 64'(out_valid), 64'd0);

    // Duplicate window: +5 is a duplicate, +8 (from the accepted record) is not
    send(15'h0421, 3'd1, 19'd200, 1'b1);
    send(15'h0421, 3'd1, 19'd205, 1'b0);
    chk("dup_count_1", 64'(dup_count), 64'd1);
    send(15'h0421, 3'd1, 19'd208, 1'b1);
    chk("dup_level_2", 64'(level), 64'd2);
    // Output held stable while not taken
    chk("hold_time", 64'(out_time), 64'd200);
    drain();

    // Different board is not a duplicate; blank plate ignored
    send(15'h1111, 3'd2, 19'd300, 1'b1);
    send(15'h1111, 3'd3, 19'd301, 1'b1);
    send(15'h0000, 3'd3, 19'd301, 1'b0);
    send(15'h0000, 3'd5, 19'd900, 1'b0);
    chk("board_level", 64'(level), 64'd2);
    chk("blank_dup", 64'(dup_count), 64'd1);
    chk("blank_drop", 64'(drop_count), 64'd0);
    drain();

    // Fill to full, overflow drops, duplicate while full still counts as dup
    for (int i = 0; i < 16; i++)
      send(15'(100 + i), 3'(i % 5), 19'(1000 + i * 20), 1'b1);
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    for (int j = 0; j < 3; j++)
      send(15'(200 + j), 3'd1, 19'(2000 + j * 50), 1'b0);
    chk("fill_drop", 64'(drop_count), 64'd3);
    send(15'(115), 3'd0, 19'(1000 + 15 * 20 + 1), 1'b0);
    chk("full_dup", 64'(dup_count), 64'd2);
    chk("full_drop_hold", 64'(drop_count), 64'd3);
    drain();

    // Pointer wrap with a streaming consumer
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send(15'(600 + i), 3'(i % 8), 19'(3000 + i * 11), 1'b1);
    drain();

    // Level held at 5 under simultaneous write and pop
    for (int i = 0; i < 5; i++)
      send(15'(300 + i), 3'd4, 19'(4000 + i * 10), 1'b1);
    chk("hold5_level_pre", 64'(level), 64'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      send(15'(400 + i), 3'd0, 19'(5000 + i * 10), 1'b1);
    chk("hold5_level_post", 64'(level), 64'd5);
    drain();

    // Timestamp wrap: 524286 -> 3 is a difference of 5
    send(15'h2222, 3'd4, 19'd524286, 1'b1);
    send(15'h2222, 3'd4, 19'd3, 1'b0);
    chk("wrap_dup", 64'(dup_count), 64'd3);
    drain();

    // Reset during a handshake with seven records queued
    for (int i = 0; i < 7; i++)
      send(15'(500 + i), 3'd2, 19'(6000 + i * 30), 1'b1);
    chk("pre_reset_level", 64'(level), 64'd7);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_plate  = 15'h7777;
    in_board  = 3'd1;
    in_time   = 19'd7000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    chk("post_reset_level", 64'(level), 64'd0);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_empty", 64'(empty), 64'd1);
    chk("post_reset_drop", 64'(drop_count), 64'd0);
    chk("post_reset_dup", 64'(dup_count), 64'd0);
    send(15'(506), 3'd2, 19'(6000 + 6 * 30 + 1), 1'b1);
    chk("post_reset_accept", 64'(level), 64'd1);
    chk("post_reset_dup_hold", 64'(dup_count), 64'd0);
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
